wb_led_poller: RTL and testbench
================================

# wb_led_poller

Wishbone initiator that drives the button/LED peripheral autonomously. On a fixed poll interval it reads the button register, detects new presses, toggles the corresponding LED bit, and writes the LED register back. It sits on the user-area Wishbone bus as a second master beside the CPU, behind the bus arbiter. It gives the chip a CPU-independent button→LED self-test.

## Interface

Parameters:
- POLL_CYCLES, 1000: clk cycles between button reads (≥ 8).
- TIMEOUT_CYCLES, 16: cycles allowed from request issue to ack before abort.
- BUTTON_ADDR, `BUTTON_ADDRESS: button register address (user_params.svh).
- LED_ADDR, `LED_ADDRESS: LED register address (user_params.svh).

Ports:
- clk  in  1  system clock (wb_clk_i); sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  polling allowed while high.
- err_clr  in  1  clears sticky error flag.
- o_wb_cyc  out  1  bus cycle active.
- o_wb_stb  out  1  request strobe.
- o_wb_we  out  1  1 = write.
- o_wb_addr  out  32  address.
- o_wb_data  out  32  write data, {30'b0, led_state}.
- i_wb_ack  in  1  responder completion.
- i_wb_stall  in  1  responder cannot accept request.
- i_wb_data  in  32  read data; bits [1:0] = pressed buttons, active-high.
- led_state  out  2  LED value last written successfully.
- pressed  out  2  last sampled button value.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag.

## Operation

- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE: the poll counter counts while enable=1 and holds at 0 while enable=0. At count POLL_CYCLES-1 the counter wraps to 0 and the FSM moves to RD_REQ.
- RD_REQ: cyc=1, stb=1, we=0, addr=BUTTON_ADDR. The FSM stays here while i_wb_stall=1. A cycle with stb=1 and stall=0 counts as accepted, and the FSM moves to RD_WAIT.
- RD_WAIT: cyc=1, stb=0.
  - On ack, latch i_wb_data[1:0] into pressed and compute rise = new & ~pressed_prev.
  - If rise ≠ 0: next_led = led_state ^ rise, then go to WR_REQ.
  - Otherwise go to IDLE.
- WR_REQ: cyc=1, stb=1, we=1, addr=LED_ADDR, data={30'b0,next_led}. Same stall rule as RD_REQ, then go to WR_WAIT.
- WR_WAIT: on ack, led_state ← next_led, then go to IDLE.
- Timeout:
  - A counter resets on entry to RD_REQ or WR_REQ.
  - It increments every cycle in the REQ and WAIT states.
  - When it reaches TIMEOUT_CYCLES-1 without ack: drop cyc/stb, set err, discard the transaction (pressed and led_state unchanged), go to IDLE.
  - Ack in the same cycle as timeout: ack wins.
- Ack seen in a REQ state (before acceptance) is ignored.
- enable falling mid-transaction: the current transaction completes, then the FSM stays in IDLE.
- err: set by timeout, cleared by err_clr. If both occur in the same cycle, set wins.
- Reset values: all outputs 0, FSM IDLE, both counters 0, pressed_prev 0, o_wb_addr 0.
- Reset mid-transaction: cyc/stb are 0 after the next edge and no write completes.

## Timing

- Outputs are registered.
- cyc/stb assert in the cycle after the poll counter wraps.
- Zero-stall responder with one-cycle ack: read takes 2 cycles (REQ, WAIT). Read plus write, IDLE to IDLE, is 4 cycles.
- pressed and led_state update on the edge that samples ack.
- cyc deasserts on the edge after ack.
- Exactly one outstanding request at a time; no back-to-back pipelining.
- Poll period = POLL_CYCLES plus transaction cycles, because the counter is held at 0 while busy.

## Structure

- The FSM state enum and the address constants go in the shared user_params package.
- One sub-module, wb_master_single: a single-transaction initiator (req/we/addr/wdata in; done/timeout/rdata out) containing the REQ/WAIT handshake and the timeout counter.
- The top level holds the poll counter, edge detection and LED toggle logic.

## Test plan

- Zero-stall responder, POLL_CYCLES=8, buttons=2'b01 asserted → read at the 8th enabled cycle; write data 0x1; led_state=2'b01 four cycles after cyc rises.
- Button held across three polls → three reads, one write; led_state stays 01.
- Responder stalls 3 cycles on the read → stb held 4 cycles, addr stable throughout; no timeout at TIMEOUT_CYCLES=16.
- Responder never acks, TIMEOUT_CYCLES=16 → cyc drops after 16 cycles, err=1, led_state unchanged; err_clr then clears err.
- Reset asserted during WR_WAIT → cyc=stb=0 and led_state=0 after next edge; enable=0 → no cyc for 100 cycles.

Source files
------------

// File: rtl/wb_led_poller_pkg.sv
// Shared types and bus addresses for the autonomous button/LED poller.
package wb_led_poller_pkg;

  localparam logic [31:0] BUTTON_ADDRESS = 32'h3000_0000;
  localparam logic [31:0] LED_ADDRESS    = 32'h3000_0004;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } poll_state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_WAIT
  } master_state_e;

  function automatic logic [1:0] rising(input logic [1:0] now, input logic [1:0] prev);
    return now & ~prev;
  endfunction

endpackage

// File: rtl/wb_master_single.sv
// Single-transaction Wishbone initiator: request/stall handshake, ack wait and
// abort after TIMEOUT_CYCLES without ack. A new request may launch on the ack cycle.
module wb_master_single
  import wb_led_poller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        accept,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  input  logic        wb_ack,
  input  logic        wb_stall,
  input  logic [31:0] wb_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  master_state_e state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          launch;

  assign rdata = wb_rdata;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    tmo_hit    = (tmo_cnt == TMO_LAST);
    case (state)
      // ack is meaningless before acceptance, so only stall/timeout matter here
      M_REQ: begin
        if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = M_IDLE;
        end else if (!wb_stall) begin
          accept     = 1'b1;
          state_next = M_WAIT;
        end
      end
      M_WAIT: begin
        if (wb_ack) begin
          done       = 1'b1;
          state_next = M_IDLE;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = M_IDLE;
        end
      end
      default: ;
    endcase
    launch = req && (state == M_IDLE || done);
    if (launch) state_next = M_REQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= M_IDLE;
      tmo_cnt  <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_wdata <= '0;
    end else begin
      state  <= state_next;
      wb_cyc <= (state_next != M_IDLE);
      wb_stb <= (state_next == M_REQ);
      if (launch) begin
        tmo_cnt  <= '0;
        wb_we    <= req_we;
        wb_addr  <= req_addr;
        wb_wdata <= req_wdata;
      end else if (state_next != M_IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wb_led_poller.sv
// Autonomous poller: reads buttons every POLL_CYCLES, toggles LEDs on new presses.
//   state   | meaning
//   IDLE    | poll counter running (held at 0 while enable=0)
//   RD_REQ  | button read strobed, waiting for acceptance
//   RD_WAIT | button read accepted, waiting for ack
//   WR_REQ  | LED write strobed, waiting for acceptance
//   WR_WAIT | LED write accepted, waiting for ack
module wb_led_poller
  import wb_led_poller_pkg::*;
#(
  parameter int          POLL_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] BUTTON_ADDR    = BUTTON_ADDRESS,
  parameter logic [31:0] LED_ADDR       = LED_ADDRESS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        err_clr,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [1:0]  led_state,
  output logic [1:0]  pressed,
  output logic        busy,
  output logic        err
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

  poll_state_e state, state_next;
  logic [PW-1:0] poll_cnt;
  logic [1:0]    rise;
  logic [1:0]    next_led;
  logic          req, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic          accept, done, timeout;
  logic [31:0]   rdata;
  logic          unused_rdata;

  assign unused_rdata = ^rdata[31:2];

  wb_master_single #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_master (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .accept   (accept),
    .done     (done),
    .timeout  (timeout),
    .rdata    (rdata),
    .wb_cyc   (o_wb_cyc),
    .wb_stb   (o_wb_stb),
    .wb_we    (o_wb_we),
    .wb_addr  (o_wb_addr),
    .wb_wdata (o_wb_data),
    .wb_ack   (i_wb_ack),
    .wb_stall (i_wb_stall),
    .wb_rdata (i_wb_data)
  );

  always_comb begin
    state_next = state;
    req        = 1'b0;
    req_we     = 1'b0;
    req_addr   = BUTTON_ADDR;
    req_wdata  = '0;
    rise       = rising(rdata[1:0], pressed);
    case (state)
      IDLE:    if (enable && poll_cnt == POLL_LAST) begin
                 req        = 1'b1;
                 state_next = RD_REQ;
               end
      RD_REQ:  if (timeout) state_next = IDLE;
               else if (accept) state_next = RD_WAIT;
      RD_WAIT: if (done) begin
                 if (rise != 2'b00) begin
                   req        = 1'b1;
                   req_we     = 1'b1;
                   req_addr   = LED_ADDR;
                   req_wdata  = {30'b0, led_state ^ rise};
                   state_next = WR_REQ;
                 end else begin
                   state_next = IDLE;
                 end
               end else if (timeout) begin
                 state_next = IDLE;
               end
      WR_REQ:  if (timeout) state_next = IDLE;
               else if (accept) state_next = WR_WAIT;
      WR_WAIT: if (done || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      next_led  <= '0;
      led_state <= '0;
      pressed   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      // held at 0 while busy so the period stretches by the transaction length
      if (state != IDLE || !enable || poll_cnt == POLL_LAST) poll_cnt <= '0;
      else poll_cnt <= poll_cnt + PW'(1);
      if (state == RD_WAIT && done) begin
        pressed  <= rdata[1:0];
        next_led <= req_wdata[1:0];
      end
      if (state == WR_WAIT && done) led_state <= next_led;
      if (timeout) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_led_poller.sv
// Scoreboard bench for wb_led_poller: expected bus requests are queued by the
// stimulus and checked by a monitor whenever the DUT issues an accepted request.
module tb_wb_led_poller;
  import wb_led_poller_pkg::*;

  localparam int POLL = 8;
  localparam int TMO  = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  led;
    logic [1:0]  pr;
  } exp_t;

  logic        clk, reset, enable, err_clr;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        ack, wb_stall;
  logic [31:0] rd_data;
  logic [1:0]  led_state, pressed;
  logic        busy, err;

  logic [1:0]  btn;
  logic [29:0] hi_bits;
  logic        no_ack;
  int unsigned stall_req, stall_seen;

  exp_t q[$];
  exp_t mon_e;
  logic [1:0] model_led, model_prev;
  int vectors, miscompares;

  wb_led_poller #(
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .err_clr(err_clr),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(ack), .i_wb_stall(wb_stall), .i_wb_data(rd_data),
    .led_state(led_state), .pressed(pressed), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data  = {hi_bits, btn};
  assign wb_stall = o_wb_cyc && o_wb_stb && (stall_seen < stall_req);

  // responder: optional stall count per request, one-cycle registered ack
  always @(posedge clk) begin
    if (reset) begin
      ack        <= 1'b0;
      stall_seen <= 0;
    end else begin
      ack <= o_wb_cyc && o_wb_stb && !wb_stall && !no_ack;
      if (!o_wb_stb) stall_seen <= 0;
      else if (wb_stall) stall_seen <= stall_seen + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && o_wb_cyc && o_wb_stb && !wb_stall) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_request: got we=%0d addr=0x%0h, required no request", o_wb_we, o_wb_addr);
      end else begin
        mon_e = q.pop_front();
        chk("req_we", {31'b0, o_wb_we}, {31'b0, mon_e.we});
        chk("req_addr", o_wb_addr, mon_e.addr);
        if (mon_e.we) chk("req_wdata", o_wb_data, mon_e.data);
        chk("led_at_req", {30'b0, led_state}, {30'b0, mon_e.led});
        chk("pressed_at_req", {30'b0, pressed}, {30'b0, mon_e.pr});
      end
    end
  end

  // reference: a poll reads the buttons; new presses toggle LEDs and cause a write
  task automatic push_poll(input logic [1:0] b);
    exp_t e;
    logic [1:0] r;
    btn = b;
    r = b & ~model_prev;
    e = '{we: 1'b0, addr: BUTTON_ADDRESS, data: 32'h0, led: model_led, pr: model_prev};
    q.push_back(e);
    model_prev = b;
    if (r != 2'b00) begin
      e = '{we: 1'b1, addr: LED_ADDRESS, data: {30'b0, model_led ^ r}, led: model_led, pr: b};
      q.push_back(e);
      model_led = model_led ^ r;
    end
  endtask

  task automatic push_read_only();
    exp_t e;
    e = '{we: 1'b0, addr: BUTTON_ADDRESS, data: 32'h0, led: model_led, pr: model_prev};
    q.push_back(e);
  endtask

  task automatic wait_txn(output int gap);
    int n;
    n = 0;
    while (!busy && n < 100) begin @(posedge clk); #1; n++; end
    gap = n;
    chk("txn_start", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("txn_end", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap;
    logic addr_ok;
    vectors = 0; miscompares = 0;
    reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
    btn = 2'b00; hi_bits = '0; no_ack = 1'b0; stall_req = 0;
    model_led = 2'b00; model_prev = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc_stb", {30'b0, o_wb_cyc, o_wb_stb}, 32'h0);
    chk("rst_addr", o_wb_addr, 32'h0);
    chk("rst_data", o_wb_data, 32'h0);
    chk("rst_led_pressed", {28'b0, led_state, pressed}, 32'h0);
    chk("rst_busy_err_we", {29'b0, busy, err, o_wb_we}, 32'h0);

    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    push_poll(2'b01);
    enable = 1'b1;
    n = 0;
    while (!o_wb_cyc && n < 50) begin @(posedge clk); #1; n++; end
    chk("first_read_edge", n, POLL);
    chk("first_read_stb", {31'b0, o_wb_stb}, 32'h1);
    n = 0;
    while (led_state != 2'b01 && n < 20) begin @(posedge clk); #1; n++; end
    chk("led_after_cyc", n, 4);
    chk("cyc_drop_after_ack", {30'b0, o_wb_cyc, busy}, 32'h0);

    for (int i = 0; i < 3; i++) begin
      push_poll(2'b01);
      wait_txn(gap);
      chk("held_gap", gap, POLL);
      chk("held_led", {30'b0, led_state}, 32'h1);
    end

    stall_req = 3;
    push_poll(2'b10);
    n = 0;
    while (!o_wb_cyc && n < 50) begin @(posedge clk); #1; n++; end
    n = 0;
    addr_ok = 1'b1;
    while (o_wb_stb && !o_wb_we && n < 40) begin
      if (o_wb_addr != BUTTON_ADDRESS) addr_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk("stall_stb_cycles", n, 4);
    chk("stall_addr_stable", {31'b0, addr_ok}, 32'h1);
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall_no_err", {31'b0, err}, 32'h0);
    chk("stall_led", {30'b0, led_state}, {30'b0, model_led});

    for (int i = 0; i < 20; i++) begin
      stall_req = $urandom_range(0, 3);
      hi_bits   = 30'($urandom);
      push_poll(2'($urandom_range(0, 3)));
      wait_txn(gap);
      chk("rand_gap", gap, POLL);
      chk("rand_led", {30'b0, led_state}, {30'b0, model_led});
      chk("rand_pressed", {30'b0, pressed}, {30'b0, model_prev});
      chk("rand_err", {31'b0, err}, 32'h0);
    end

    stall_req = 0;
    no_ack = 1'b1;
    btn = ~model_prev;
    push_read_only();
    n = 0;
    while (!o_wb_cyc && n < 50) begin @(posedge clk); #1; n++; end
    n = 0;
    while (o_wb_cyc && n < 100) begin @(posedge clk); #1; n++; end
    chk("timeout_cyc_cycles", n, TMO);
    chk("timeout_err", {31'b0, err}, 32'h1);
    chk("timeout_led", {30'b0, led_state}, {30'b0, model_led});
    chk("timeout_pressed", {30'b0, pressed}, {30'b0, model_prev});
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_clr", {31'b0, err}, 32'h0);
    push_read_only();
    wait_txn(gap);
    chk("err_set_wins", {31'b0, err}, 32'h1);
    err_clr = 1'b0;
    no_ack = 1'b0;

    push_poll(2'b00);
    wait_txn(gap);
    push_poll(2'b01);
    n = 0;
    while (!(o_wb_cyc && o_wb_we && !o_wb_stb) && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_wr_wait", {31'b0, o_wb_cyc && o_wb_we && !o_wb_stb}, 32'h1);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    model_led = 2'b00; model_prev = 2'b00;
    chk("midrst_cyc_stb", {30'b0, o_wb_cyc, o_wb_stb}, 32'h0);
    chk("midrst_led", {30'b0, led_state}, 32'h0);
    chk("midrst_busy_err", {30'b0, busy, err}, 32'h0);
    chk("queue_drained", q.size(), 0);
    @(negedge clk) reset = 1'b0;
    n = 0;
    repeat (100) begin @(posedge clk); #1; if (o_wb_cyc) n++; end
    chk("disabled_no_cyc", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
